// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and instruction memory.
// The master side (pc_gen) drives the request and address; memory answers with ready.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Holds the architectural fetch PC and offers it to instruction memory
// through a valid/ready request. Redirects (trap, JALR, JAL, taken branch)
// are computed from the execute-stage PC. A misaligned control-transfer
// target parks the generator in FAULT until a trap redirect arrives.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_stall,
    input  logic            i_trap_en,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_jalr_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic            i_jal_en,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_imm,
    pc_gen_if.master        imem,
    output logic            o_flush,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_bad_addr
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_bad_addr;
    logic            r_flush;
    logic            r_misalign;

    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_rel_tgt;
    logic [XLEN-1:0] w_tgt;
    logic            w_redirect;
    logic            w_tgt_misaligned;
    logic            w_req_valid;
    logic            w_fire;

    // Redirect target selection; JALR outranks JAL/branch when both are raised.
    always_comb begin
        w_jalr_tgt       = (i_rs1 + i_imm) & JALR_MASK;
        w_rel_tgt        = i_ex_pc + i_imm;
        w_tgt            = i_jalr_en ? w_jalr_tgt : w_rel_tgt;
        w_redirect       = i_jalr_en | i_jal_en | i_br_taken;
        w_tgt_misaligned = (IALIGN == 2) ? w_tgt[0] : (|w_tgt[1:0]);
        w_req_valid      = (r_state == S_RUN) && !i_stall;
        w_fire           = w_req_valid && imem.imem_req_ready;
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_addr      = r_pc;
    assign o_flush             = r_flush;
    assign o_misalign          = r_misalign;
    assign o_bad_addr          = r_bad_addr;

    // Control FSM: PC update, fault entry/exit and the registered pulse outputs.
    // A redirect replaces the PC even if the current request was not accepted;
    // that request is simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_bad_addr <= '0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (i_trap_en) begin
                        r_pc    <= i_trap_vec;
                        r_flush <= 1'b1;
                    end else if (w_redirect) begin
                        r_flush <= 1'b1;
                        if (w_tgt_misaligned) begin
                            r_misalign <= 1'b1;
                            r_bad_addr <= w_tgt;
                            r_state    <= S_FAULT;
                        end else begin
                            r_pc <= w_tgt;
                        end
                    end else if (w_fire) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                S_FAULT: begin
                    if (i_trap_en) begin
                        r_pc    <= i_trap_vec;
                        r_flush <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed vector table, an asynchronous reset check,
// then randomized traffic compared against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall, trap_en, jalr_en, jal_en, br_taken;
    logic [31:0] trap_vec, rs1, ex_pc, imm;
    logic        flush, misalign;
    logic [31:0] bad_addr;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_if #(.XLEN(32)) u_if ();

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .IALIGN(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_stall    (stall),
        .i_trap_en  (trap_en),
        .i_trap_vec (trap_vec),
        .i_jalr_en  (jalr_en),
        .i_rs1      (rs1),
        .i_jal_en   (jal_en),
        .i_br_taken (br_taken),
        .i_ex_pc    (ex_pc),
        .i_imm      (imm),
        .imem       (u_if.master),
        .o_flush    (flush),
        .o_misalign (misalign),
        .o_bad_addr (bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, trap, jalr, jal, br, ready;
        logic [31:0] tv, rs1, ex_pc, imm;
        logic        ev;      // valid expected during the cycle (before edge)
        logic [31:0] ea;      // address expected after the edge
        logic        ef, em;  // flush / misalign expected after the edge
        logic [31:0] eb;      // bad_addr expected after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic s, logic t, logic jr, logic j, logic b, logic r,
                                 logic [31:0] tv, logic [31:0] r1, logic [31:0] ep,
                                 logic [31:0] im, logic ev, logic [31:0] ea,
                                 logic ef, logic em, logic [31:0] eb);
        vec_t v;
        v.stall = s; v.trap = t; v.jalr = jr; v.jal = j; v.br = b; v.ready = r;
        v.tv = tv; v.rs1 = r1; v.ex_pc = ep; v.imm = im;
        v.ev = ev; v.ea = ea; v.ef = ef; v.em = em; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic t, input logic jr, input logic j,
                         input logic b, input logic r, input logic [31:0] tv,
                         input logic [31:0] r1, input logic [31:0] ep, input logic [31:0] im);
        stall = s; trap_en = t; jalr_en = jr; jal_en = j; br_taken = b;
        u_if.imem_req_ready = r;
        trap_vec = tv; rs1 = r1; ex_pc = ep; imm = im;
    endtask

    // Behavioural reference state
    logic [31:0] m_pc, m_bad;
    bit          m_booting, m_faulted, m_flush, m_mis;

    task automatic model_reset();
        m_pc = RV; m_bad = 0; m_booting = 1; m_faulted = 0; m_flush = 0; m_mis = 0;
    endtask

    function automatic bit model_valid();
        return !m_booting && !m_faulted && !stall;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] t;
        m_flush = 0;
        m_mis   = 0;
        if (m_booting) begin
            m_booting = 0;
        end else if (m_faulted) begin
            if (trap_en) begin
                m_pc = trap_vec; m_faulted = 0; m_flush = 1;
            end
        end else if (trap_en) begin
            m_pc = trap_vec; m_flush = 1;
        end else if (jalr_en || jal_en || br_taken) begin
            if (jalr_en) begin
                t = rs1 + imm;
                t = t - (t % 2);
            end else begin
                t = ex_pc + imm;
            end
            m_flush = 1;
            if (t % 4 != 0) begin
                m_mis = 1; m_bad = t; m_faulted = 1;
            end else begin
                m_pc = t;
            end
        end else if (!stall && u_if.imem_req_ready) begin
            m_pc = m_pc + 4;
        end
    endtask

    initial begin
        vec_t v;
        logic s, t, jr, j, b, r;
        logic [31:0] tv, r1, ep, im;

        //            st tr jr jl br rd  trap_vec      rs1           ex_pc         imm           ev  addr          fl mi bad
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h100,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h104,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h108,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 0, 1, 1, 32'h800,      32'h200,      32'h40,       32'h5,        1, 32'h800,      1, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 1, 0, 1, 1, 32'h800,      32'h200,      32'h40,       32'h5,        1, 32'h204,      1, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h208,      0, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h40,       32'hFFFFFFF8, 1, 32'h38,       1, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h1000,     32'h10,       0, 32'h1010,     1, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h20,       32'h8,        1, 32'h28,       1, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h10,       32'h6,        1, 32'h28,       1, 1, 32'h16));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h10,       32'h8,        0, 32'h28,       0, 0, 32'h16));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h28,       0, 0, 32'h16));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'h80,       32'h0,        32'h0,        32'h0,        0, 32'h80,       1, 0, 32'h16));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h84,       0, 0, 32'h16));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 32'h0,        32'h11,       32'h0,        32'h1,        1, 32'h84,       1, 1, 32'h12));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFC, 1, 0, 32'h12));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h0,        0, 0, 32'h12));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h4,        0, 0, 32'h12));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 32'h0,        32'hFFFFFFF0, 32'h0,        32'h20,       1, 32'h10,       1, 0, 32'h12));

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset addr", u_if.imem_addr, RV);
        check("reset valid", 32'(u_if.imem_req_valid), 0);
        check("reset flush", 32'(flush), 0);
        check("reset misalign", 32'(misalign), 0);
        check("reset bad_addr", bad_addr, 0);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.stall, v.trap, v.jalr, v.jal, v.br, v.ready, v.tv, v.rs1, v.ex_pc, v.imm);
            #1;
            check($sformatf("vec%0d valid", i), 32'(u_if.imem_req_valid), 32'(v.ev));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d addr", i), u_if.imem_addr, v.ea);
            check($sformatf("vec%0d flush", i), 32'(flush), 32'(v.ef));
            check($sformatf("vec%0d misalign", i), 32'(misalign), 32'(v.em));
            check($sformatf("vec%0d bad_addr", i), bad_addr, v.eb);
            $display("[TB] vec%0d addr=%h valid_pre=%0d flush=%0d mis=%0d", i,
                     u_if.imem_addr, v.ev, flush, misalign);
        end

        // Asynchronous reset between clock edges
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async reset addr", u_if.imem_addr, RV);
        check("async reset valid", 32'(u_if.imem_req_valid), 0);
        check("async reset bad_addr", bad_addr, 0);
        $display("[TB] async reset addr=%h valid=%0d", u_if.imem_addr, u_if.imem_req_valid);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Randomized traffic against the behavioural model
        for (int c = 0; c < 400; c++) begin
            s  = ($urandom_range(0, 4) == 0);
            t  = ($urandom_range(0, 9) == 0);
            jr = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 3) != 0);
            tv = $urandom & 32'hFFFFFFFC;
            r1 = $urandom;
            ep = $urandom & 32'hFFFFFFFC;
            im = $urandom;
            if ($urandom_range(0, 1) == 0) im = im & 32'hFFFFFFFC;
            drive(s, t, jr, j, b, r, tv, r1, ep, im);
            #1;
            check($sformatf("rand%0d valid", c), 32'(u_if.imem_req_valid), 32'(model_valid()));
            model_edge();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rand%0d addr", c), u_if.imem_addr, m_pc);
            check($sformatf("rand%0d flush", c), 32'(flush), 32'(m_flush));
            check($sformatf("rand%0d misalign", c), 32'(misalign), 32'(m_mis));
            check($sformatf("rand%0d bad_addr", c), bad_addr, m_bad);
            $display("[TB] rand%0d addr=%h flush=%0d mis=%0d bad=%h", c,
                     u_if.imem_addr, flush, misalign, bad_addr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the RV32I core. It holds the architectural fetch PC and drives it to instruction memory through a valid/ready request handshake. It selects the next PC from, in priority order: trap vector, JALR, JAL, taken branch, stall hold, sequential increment. Redirect targets come from the execute-stage PC supplied with the redirect, not from the current fetch PC, so no pipeline-depth offset correction is applied. Misaligned control-transfer targets are trapped internally.

## Interface
- XLEN, 32, PC and address width
- RESET_VEC, 0, PC value loaded on reset (XLEN bits, must be IALIGN-aligned)
- IALIGN, 4, instruction alignment in bytes (2 or 4); sequential step is always 4
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC, suppress new request
- trap_en  in  1  redirect to trap_vec (highest priority)
- trap_vec  in  XLEN  trap handler address
- jalr_en  in  1  JALR resolved in execute
- rs1  in  XLEN  JALR base register value
- jal_en  in  1  JAL resolved in execute
- br_taken  in  1  conditional branch resolved taken
- ex_pc  in  XLEN  PC of the instruction in execute
- imm  in  XLEN  sign-extended J/B/I immediate for the redirecting instruction
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  instruction memory accepts request
- imem_addr  out  XLEN  fetch address (= PC)
- flush  out  1  one-cycle pulse: squash fetch/decode
- misalign  out  1  one-cycle pulse: misaligned target detected
- bad_addr  out  XLEN  offending target, held until next misalign or reset

## Operation
- FSM states: BOOT, RUN, FAULT.
- BOOT: entered on reset. imem_req_valid=0. Always moves to RUN on the next edge.
- RUN: imem_req_valid = !stall. Next-PC selection:
  - trap_en: PC <= trap_vec.
  - jalr_en: target = (rs1 + imm) & ~1.
  - jal_en or br_taken: target = ex_pc + imm.
  - else if stall, or no handshake (valid && ready false): PC holds.
  - else PC <= PC + 4.
- Redirect precedence: any redirect overrides stall and the handshake. An un-accepted request at the old PC is dropped, not replayed.
- Misalignment: if a jalr/jal/branch target mod IALIGN != 0:
  - PC holds, misalign pulses, bad_addr <= target, flush pulses, FSM -> FAULT.
  - trap_en is never checked for alignment.
- FAULT: imem_req_valid=0 and PC holds. Only trap_en leaves FAULT (PC <= trap_vec, flush pulses, -> RUN). Other redirects and stall are ignored.
- Simultaneous redirect inputs: the highest priority wins; lower ones are ignored.
- Arithmetic is modulo 2^XLEN. PC = 2^XLEN-4 increments to 0; target sums wrap silently.

## Timing
- Reset values: PC = RESET_VEC, state = BOOT, imem_req_valid=0, imem_addr=RESET_VEC, flush=0, misalign=0, bad_addr=0.
- Reset assertion mid-operation takes effect immediately (asynchronous), regardless of clk. Deassertion is sampled at the next rising edge.
- First request: imem_req_valid rises the cycle after the first edge with reset_n high, at address RESET_VEC.
- imem_addr is stable while imem_req_valid=1 && imem_req_ready=0, unless a redirect arrives.
- Redirect latency: redirect sampled at edge N gives new imem_addr at N (visible after N). flush and misalign are registered and are high for exactly the cycle after edge N.
- Back-to-back redirects on consecutive cycles each take effect. flush stays high for both cycles.
- Throughput: one PC advance per cycle while ready=1 and stall=0.

## Test plan
- Reset/boot: RESET_VEC=0x100, release reset_n, ready=1 -> valid low 1 cycle, then imem_addr 0x100, 0x104, 0x108 on successive cycles.
- Backpressure and stall: ready=0 for 3 cycles at 0x104 -> addr holds 0x104. Then stall=1 for 2 cycles -> valid=0, addr holds. Release both -> 0x108.
- Priority: trap_en (trap_vec=0x800), jalr_en (rs1=0x200, imm=5) and br_taken asserted in the same cycle -> addr 0x800, flush 1 cycle. Same cycle without trap_en -> addr 0x204 (bit0 cleared).
- Branch from execute PC: ex_pc=0x40, imm=-8, br_taken -> addr 0x38, independent of the current fetch PC.
- Misalignment: IALIGN=4, jal_en with ex_pc=0x10, imm=6:
  - -> misalign pulse, bad_addr 0x16, valid=0, PC unchanged.
  - Then jal_en again -> still FAULT.
  - trap_en with trap_vec=0x80 -> RUN, addr 0x80.
- Wrap and async reset: PC=0xFFFFFFFC, advance -> 0x0. Pull reset_n low between clock edges -> imem_addr=RESET_VEC and valid=0 immediately.
